// File: rtl/bus16_arbiter.sv
// bus16_arbiter: two-requester round-robin arbiter and sequencer for one
// shared 16-bit valid/ready write port. The block owns the 2:1 data select,
// counts beats per grant and forces a release at MAX_BURST beats.
// Optional feature macro: ARB_TIMEOUT_EN adds an idle-owner timeout (TIMEOUT
// cycles with the granted request low) that forces a release and pulses
// o_timeout for one cycle. Without it a stalled owner keeps the bus.
module bus16_arbiter #(
  parameter int unsigned MAX_BURST = 8
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_a,
  input  logic [15:0] i_data_a,
  input  logic        i_last_a,
  input  logic        i_req_b,
  input  logic [15:0] i_data_b,
  input  logic        i_last_b,
  output logic        o_gnt_a,
  output logic        o_gnt_b,
  output logic        o_sel,
  output logic        o_out_valid,
  output logic [15:0] o_out_data,
  output logic        o_out_last,
  input  logic        i_out_ready,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  // Beat count value on which the burst limit forces out_last.
  localparam logic [7:0] LP_LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_sel;
  logic       r_ptr;          // 0 = A has priority on a tie, 1 = B
  logic [7:0] r_beat_cnt;

  logic       w_owned;
  logic       w_owner_b;
  logic       w_owner_req;
  logic       w_other_req;
  logic       w_owner_last;
  logic       w_valid;
  logic       w_last;
  logic       w_beat;
  logic       w_keep_self;
  logic       w_timeout_rel;
  logic       w_release;

  // Decode the current owner and form its beat handshake and last flag
  always_comb begin
    w_owned      = 1'b0;
    w_owner_b    = 1'b0;
    w_owner_req  = 1'b0;
    w_other_req  = 1'b0;
    w_owner_last = 1'b0;
    case (r_state)
      ST_OWN_A: begin
        w_owned      = 1'b1;
        w_owner_req  = i_req_a;
        w_other_req  = i_req_b;
        w_owner_last = i_last_a;
      end
      ST_OWN_B: begin
        w_owned      = 1'b1;
        w_owner_b    = 1'b1;
        w_owner_req  = i_req_b;
        w_other_req  = i_req_a;
        w_owner_last = i_last_b;
      end
      default: begin
        w_owned = 1'b0;
      end
    endcase
    w_valid = w_owned & w_owner_req;
    w_last  = w_owned & (w_owner_last | (r_beat_cnt == LP_LAST_BEAT));
    w_beat  = w_valid & i_out_ready;
    // A requester that signalled its own last has finished; only a burst cut
    // short by the limit (or a re-raised request after timeout) keeps going.
    w_keep_self = w_owner_req & ~w_owner_last;
  end

  assign w_release = w_owned & ((w_beat & w_last) | w_timeout_rel);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic [7:0] w_idle_cnt_nxt;
  logic       r_timeout;

  assign w_timeout_rel = w_owned & (r_idle_cnt == 8'(TIMEOUT));

  // Advance the idle counter while the owner holds the grant with req low
  always_comb begin
    if (w_owned & ~w_release & ~w_owner_req) begin
      w_idle_cnt_nxt = r_idle_cnt + 8'd1;
    end else begin
      w_idle_cnt_nxt = 8'd0;
    end
  end

  // Idle counter and timeout pulse registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_cnt_nxt;
      r_timeout  <= (w_idle_cnt_nxt == 8'(TIMEOUT));
    end
  end
`else
  assign w_timeout_rel = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next owner: arbitrate from IDLE, or hand over in the release cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req_a & i_req_b) begin
          w_state_nxt = r_ptr ? ST_OWN_B : ST_OWN_A;
        end else if (i_req_a) begin
          w_state_nxt = ST_OWN_A;
        end else if (i_req_b) begin
          w_state_nxt = ST_OWN_B;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN_A: begin
        if (w_release) begin
          if (w_other_req) begin
            w_state_nxt = ST_OWN_B;
          end else if (w_keep_self) begin
            w_state_nxt = ST_OWN_A;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_OWN_A;
        end
      end
      ST_OWN_B: begin
        if (w_release) begin
          if (w_other_req) begin
            w_state_nxt = ST_OWN_A;
          end else if (w_keep_self) begin
            w_state_nxt = ST_OWN_B;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_OWN_B;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Select, round-robin pointer and beat counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel      <= 1'b0;
      r_ptr      <= 1'b0;
      r_beat_cnt <= 8'd0;
    end else begin
      if (w_state_nxt == ST_OWN_A) begin
        r_sel <= 1'b0;
      end else if (w_state_nxt == ST_OWN_B) begin
        r_sel <= 1'b1;
      end else begin
        r_sel <= r_sel;
      end
      if (w_release) begin
        r_ptr <= ~w_owner_b;
      end else begin
        r_ptr <= r_ptr;
      end
      if (~w_owned | w_release) begin
        r_beat_cnt <= 8'd0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end else begin
        r_beat_cnt <= r_beat_cnt;
      end
    end
  end

  // Drive grants from state flops and pass the owner's beat through the mux
  always_comb begin
    o_gnt_a     = (r_state == ST_OWN_A);
    o_gnt_b     = (r_state == ST_OWN_B);
    o_sel       = r_sel;
    o_out_valid = w_valid;
    o_out_last  = w_last;
    if (r_sel) begin
      o_out_data = i_data_b;
    end else begin
      o_out_data = i_data_a;
    end
`ifdef ARB_TIMEOUT_EN
    o_timeout = r_timeout;
`else
    o_timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus16_arbiter.sv
// Self-checking bench for bus16_arbiter: directed scenarios with literal
// expectations plus a burst-level reference model compared every cycle.
module tb_bus16_arbiter;

  localparam int MAX_BURST = 8;
`ifdef ARB_TIMEOUT_EN
  localparam int TIMEOUT = 15;
`endif

  logic        clk;
  logic        rst;
  logic        req_a, req_b, last_a, last_b, out_ready;
  logic [15:0] data_a, data_b;
  logic        gnt_a, gnt_b, sel, out_valid, out_last, tmo;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, beats in this grant, tie priority,
  // last selected side, idle cycles of the owner.
  int m_owner;   // 0 none, 1 A, 2 B
  int m_beats;
  int m_idle;
  bit m_ptr;     // 1 = B wins a tie
  bit m_sel;

  bus16_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_a     (req_a),
    .i_data_a    (data_a),
    .i_last_a    (last_a),
    .i_req_b     (req_b),
    .i_data_b    (data_b),
    .i_last_b    (last_b),
    .o_gnt_a     (gnt_a),
    .o_gnt_b     (gnt_b),
    .o_sel       (sel),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .i_out_ready (out_ready),
    .o_timeout   (tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic own_req(input int o);
    if (o == 1) return req_a;
    else if (o == 2) return req_b;
    else return 1'b0;
  endfunction

  function automatic logic own_last(input int o);
    if (o == 1) return last_a;
    else if (o == 2) return last_b;
    else return 1'b0;
  endfunction

  function automatic logic exp_last();
    return (m_owner != 0) && (own_last(m_owner) || (m_beats == MAX_BURST - 1));
  endfunction

  function automatic logic timeout_now();
`ifdef ARB_TIMEOUT_EN
    return (m_owner != 0) && (m_idle == TIMEOUT);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic finishing();
    return (m_owner != 0) &&
           ((own_req(m_owner) && out_ready && exp_last()) || timeout_now());
  endfunction

  function automatic int next_owner();
    int other;
    if (m_owner == 0) begin
      if (req_a && req_b) return m_ptr ? 2 : 1;
      if (req_a) return 1;
      if (req_b) return 2;
      return 0;
    end
    if (!finishing()) return m_owner;
    other = 3 - m_owner;
    if (own_req(other)) return other;
    if (own_req(m_owner) && !own_last(m_owner)) return m_owner;
    return 0;
  endfunction

  // Model update at each clock edge, reset asynchronously like the design
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= 0;
      m_beats <= 0;
      m_idle  <= 0;
      m_ptr   <= 1'b0;
      m_sel   <= 1'b0;
    end else begin
      m_owner <= next_owner();
      if (next_owner() != 0) m_sel <= (next_owner() == 2);
      if (finishing()) m_ptr <= (m_owner == 1);
      if (m_owner == 0 || finishing()) m_beats <= 0;
      else if (own_req(m_owner) && out_ready) m_beats <= m_beats + 1;
      if (m_owner != 0 && !finishing() && !own_req(m_owner)) m_idle <= m_idle + 1;
      else m_idle <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("gnt_a", gnt_a, m_owner == 1);
    chk("gnt_b", gnt_b, m_owner == 2);
    chk("sel", sel, m_sel);
    chk("out_valid", out_valid, own_req(m_owner));
    chk("out_last", out_last, exp_last());
    chk("out_data", out_data, m_sel ? data_b : data_a);
    chk("timeout", tmo, timeout_now());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    // Reset with both requesting
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b0;
    data_a = 16'h0000; data_b = 16'h0000; out_ready = 1'b1;
    tick(); tick();
    neg();
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_gnt_b", gnt_b, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_model_owner", m_owner, 0);

    // Single A burst, last on beat 3
    tick();
    rst = 1'b0; req_a = 1'b1; req_b = 1'b0; data_a = 16'h1234;
    neg();
    chk("a_latency_gnt", gnt_a, 1'b0);
    tick(); neg();
    chk("a_b1_gnt", gnt_a, 1'b1);
    chk("a_b1_valid", out_valid, 1'b1);
    chk("a_b1_data", out_data, 16'h1234);
    chk("a_b1_last", out_last, 1'b0);
    chk("a_model_owner", m_owner, 1);
    tick(); neg();
    chk("a_b2_data", out_data, 16'h1234);
    tick(); last_a = 1'b1; neg();
    chk("a_b3_last", out_last, 1'b1);
    chk("a_b3_data", out_data, 16'h1234);
    tick(); req_a = 1'b0; last_a = 1'b0; neg();
    chk("a_idle_gnt_a", gnt_a, 1'b0);
    chk("a_idle_gnt_b", gnt_b, 1'b0);
    chk("a_idle_sel", sel, 1'b0);

    // Contention with last on every beat: B first (pointer moved off A)
    tick();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b1;
    data_a = 16'hAAAA; data_b = 16'hBBBB;
    neg();
    chk("rr_latency", gnt_a | gnt_b, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bit exp_b;
      exp_b = (k % 2 == 0);
      tick();
      if (k == 3) req_b = 1'b0;
      neg();
      chk("rr_gnt_b", gnt_b, exp_b);
      chk("rr_gnt_a", gnt_a, !exp_b);
      chk("rr_sel", sel, exp_b);
      chk("rr_data", out_data, exp_b ? 16'hBBBB : 16'hAAAA);
    end
    tick(); req_a = 1'b0; last_a = 1'b0; last_b = 1'b0; neg();
    chk("rr_idle", gnt_a | gnt_b, 1'b0);
    chk("rr_idle_sel", sel, 1'b0);

    // Burst limit on B: forced last on beat 8, B kept, then handed to A
    tick(); req_b = 1'b1; data_b = 16'hBEEF; neg();
    chk("bl_latency", gnt_b, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick(); neg();
      chk("bl1_gnt_b", gnt_b, 1'b1);
      chk("bl1_last", out_last, i == 8);
    end
    tick(); req_a = 1'b1; neg();
    chk("bl_keep_b", gnt_b, 1'b1);
    chk("bl_keep_last", out_last, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      tick(); neg();
      chk("bl2_gnt_b", gnt_b, 1'b1);
      chk("bl2_last", out_last, i == 8);
    end

    // Backpressure on A: 2 beats, 5 stalled cycles, forced last on beat 8
    tick(); req_b = 1'b0; data_a = 16'h5A5A; neg();
    chk("bp_gnt_a", gnt_a, 1'b1);
    chk("bp_sel", sel, 1'b0);
    chk("bp_data", out_data, 16'h5A5A);
    tick(); neg();
    tick(); out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      neg();
      chk("bp_stall_gnt", gnt_a, 1'b1);
      chk("bp_stall_last", out_last, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int b = 3; b <= 8; b++) begin
      neg();
      chk("bp_last", out_last, b == 8);
      tick();
    end

    // Idle owner A while B requests
    req_a = 1'b0; req_b = 1'b1;
    for (int c = 0; c < 20; c++) begin
      neg();
`ifdef ARB_TIMEOUT_EN
      chk("to_gnt_a", gnt_a, c <= 15);
      chk("to_gnt_b", gnt_b, c >= 16);
      chk("to_pulse", tmo, c == 15);
`else
      chk("hold_gnt_a", gnt_a, 1'b1);
      chk("hold_gnt_b", gnt_b, 1'b0);
      chk("hold_valid", out_valid, 1'b0);
      chk("hold_timeout", tmo, 1'b0);
`endif
      tick();
    end

    // Reset asserted mid-beat
    req_a = 1'b1;
    #2;
    rst = 1'b1;
    neg();
    chk("mr_gnt_a", gnt_a, 1'b0);
    chk("mr_gnt_b", gnt_b, 1'b0);
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_last", out_last, 1'b0);
    chk("mr_sel", sel, 1'b0);
    tick(); rst = 1'b0; req_a = 1'b0; req_b = 1'b0; neg();
    chk("mr_after", gnt_a | gnt_b, 1'b0);
    tick(); neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
